// File: rtl/tpu_pkg.sv
// Shared types and element widths for the TPU matrix-multiply front end.
package tpu_pkg;

   localparam int OP_W  = 8;
   localparam int ACC_W = 32;

   typedef enum logic [3:0] {
      IDLE,
      W_PUSH,
      W_LD,
      W_WAIT,
      W_SWAP,
      D_PUSH,
      M_START,
      M_WAIT,
      POP,
      CAPT,
      RESP,
      ERR
   } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter that flags when an mmu completion has been waited on for TIMEOUT cycles.
module seq_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && (cnt != LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // The first wait cycle sees cnt==0, so LIMIT is hit in the TIMEOUT-th cycle.
   assign expired = (TIMEOUT != 0) && enable && (cnt == LIMIT);

endmodule

// File: rtl/mmu_sequencer.sv
// Drives one matrix-multiply command through the mmu handshakes and returns the accumulator tile.
module mmu_sequencer
   import tpu_pkg::*;
#(
   parameter int SIZE    = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [SIZE*SIZE*OP_W-1:0]     cmd_weight,
   input  logic [SIZE*SIZE*OP_W-1:0]     cmd_data,
   input  logic                          cmd_reuse_w,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic [SIZE*SIZE*ACC_W-1:0]    result,
   output logic                          err,
   input  logic                          new_weight_rdy,
   output logic                          new_weight_push,
   output logic [SIZE*SIZE*OP_W-1:0]     new_weight_in,
   input  logic                          data_in_rdy,
   output logic                          data_in_push,
   output logic [SIZE*SIZE*OP_W-1:0]     data_in,
   input  logic                          weight_ld_rdy,
   output logic                          weight_ld_start,
   input  logic                          weight_ld_done,
   output logic                          weight_swap,
   input  logic                          mult_rdy,
   output logic                          mult_start,
   input  logic                          mult_done,
   input  logic                          acc_out_rdy,
   output logic                          acc_out_pop,
   input  logic [SIZE*SIZE*ACC_W-1:0]    acc_out
);

   seq_state_t                       state, state_nx;
   logic [SIZE*SIZE*OP_W-1:0]        w_tile, d_tile;
   logic [SIZE*SIZE*ACC_W-1:0]       result_q;
   logic                             w_valid;
   logic                             wd_clear, wd_en, wd_expired;

   assign wd_clear = (state == W_LD) || (state == M_START);
   assign wd_en    = (state == W_WAIT) || (state == M_WAIT);

   seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wd_clear),
      .enable  (wd_en),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         w_tile   <= '0;
         d_tile   <= '0;
         result_q <= '0;
         w_valid  <= 1'b0;
      end else begin
         state <= state_nx;
         if (cmd_valid && cmd_ready) begin
            w_tile <= cmd_weight;
            d_tile <= cmd_data;
         end
         if (state == W_SWAP) w_valid <= 1'b1;
         if (state == CAPT) result_q <= acc_out;
      end
   end

   always_comb begin
      state_nx        = state;
      cmd_ready       = 1'b0;
      result_valid    = 1'b0;
      err             = 1'b0;
      new_weight_push = 1'b0;
      weight_ld_start = 1'b0;
      weight_swap     = 1'b0;
      data_in_push    = 1'b0;
      mult_start      = 1'b0;
      acc_out_pop     = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nx = (!cmd_reuse_w || !w_valid) ? W_PUSH : D_PUSH;
         end
         W_PUSH: if (new_weight_rdy) begin
            new_weight_push = 1'b1;
            state_nx        = W_LD;
         end
         W_LD: if (weight_ld_rdy) begin
            weight_ld_start = 1'b1;
            state_nx        = W_WAIT;
         end
         W_WAIT: begin
            if (weight_ld_done)  state_nx = W_SWAP;
            else if (wd_expired) state_nx = ERR;
         end
         W_SWAP: begin
            weight_swap = 1'b1;
            state_nx    = D_PUSH;
         end
         D_PUSH: if (data_in_rdy) begin
            data_in_push = 1'b1;
            state_nx     = M_START;
         end
         // A done still high from a previous multiply must not be mistaken for ours.
         M_START: if (mult_rdy && !mult_done) begin
            mult_start = 1'b1;
            state_nx   = M_WAIT;
         end
         M_WAIT: begin
            if (mult_done)       state_nx = POP;
            else if (wd_expired) state_nx = ERR;
         end
         POP: if (acc_out_rdy) begin
            acc_out_pop = 1'b1;
            state_nx    = CAPT;
         end
         CAPT: state_nx = RESP;
         RESP: begin
            result_valid = 1'b1;
            if (result_ready) state_nx = IDLE;
         end
         ERR: err = 1'b1;
         default: state_nx = IDLE;
      endcase
      // Outputs are forced quiet for the whole reset cycle, not just after the edge.
      if (!rst_n) begin
         cmd_ready       = 1'b0;
         result_valid    = 1'b0;
         err             = 1'b0;
         new_weight_push = 1'b0;
         weight_ld_start = 1'b0;
         weight_swap     = 1'b0;
         data_in_push    = 1'b0;
         mult_start      = 1'b0;
         acc_out_pop     = 1'b0;
      end
   end

   assign new_weight_in = w_tile;
   assign data_in       = d_tile;
   assign result        = result_q;

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer against a small behavioural 2x2 mmu stub.
module tb_mmu_sequencer;

   localparam int SZ = 2;
   localparam int WB = SZ*SZ*8;
   localparam int RB = SZ*SZ*32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_reuse_w;
   logic [WB-1:0] cmd_weight, cmd_data;
   logic          result_valid, result_ready, err;
   logic [RB-1:0] result;
   logic          new_weight_rdy, new_weight_push;
   logic [WB-1:0] new_weight_in, data_in;
   logic          data_in_rdy, data_in_push;
   logic          weight_ld_rdy, weight_ld_start, weight_ld_done, weight_swap;
   logic          mult_rdy, mult_start, mult_done;
   logic          acc_out_rdy, acc_out_pop;
   logic [RB-1:0] acc_out;

   logic          nw_rdy, mult_hang;
   int            checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
   int            cnt_nwp = 0, cnt_ld = 0, cnt_sw = 0, cnt_dp = 0, cnt_ms = 0, cnt_pop = 0;

   mmu_sequencer #(.SIZE(SZ), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_weight(cmd_weight),
      .cmd_data(cmd_data), .cmd_reuse_w(cmd_reuse_w),
      .result_valid(result_valid), .result_ready(result_ready), .result(result), .err(err),
      .new_weight_rdy(new_weight_rdy), .new_weight_push(new_weight_push), .new_weight_in(new_weight_in),
      .data_in_rdy(data_in_rdy), .data_in_push(data_in_push), .data_in(data_in),
      .weight_ld_rdy(weight_ld_rdy), .weight_ld_start(weight_ld_start), .weight_ld_done(weight_ld_done),
      .weight_swap(weight_swap),
      .mult_rdy(mult_rdy), .mult_start(mult_start), .mult_done(mult_done),
      .acc_out_rdy(acc_out_rdy), .acc_out_pop(acc_out_pop), .acc_out(acc_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- mmu stub ----------------
   logic [WB-1:0] staged_w, loaded_w, active_w, data_q;
   logic [RB-1:0] acc_q;
   logic          acc_full, ld_done_q, mdone_q;

   assign new_weight_rdy = nw_rdy;
   assign data_in_rdy    = 1'b1;
   assign weight_ld_rdy  = 1'b1;
   assign mult_rdy       = 1'b1;
   assign acc_out_rdy    = acc_full;
   assign acc_out        = acc_q;
   assign weight_ld_done = ld_done_q;
   assign mult_done      = mdone_q;

   function automatic logic [RB-1:0] matmul(input logic [WB-1:0] w, input logic [WB-1:0] d);
      logic [RB-1:0] r;
      logic [31:0]   s;
      r = '0;
      for (int i = 0; i < SZ; i++)
         for (int j = 0; j < SZ; j++) begin
            s = '0;
            for (int k = 0; k < SZ; k++)
               s = s + 32'(w[(i*SZ+k)*8 +: 8]) * 32'(d[(k*SZ+j)*8 +: 8]);
            r[(i*SZ+j)*32 +: 32] = s;
         end
      return r;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         staged_w <= '0; loaded_w <= '0; active_w <= '0; data_q <= '0;
         acc_q <= '0; acc_full <= 1'b0; ld_done_q <= 1'b0; mdone_q <= 1'b0;
      end else begin
         if (new_weight_push) staged_w <= new_weight_in;
         if (weight_ld_start) loaded_w <= staged_w;
         if (weight_swap)     active_w <= loaded_w;
         if (data_in_push)    data_q   <= data_in;
         ld_done_q <= weight_ld_start;
         mdone_q   <= mult_start && !mult_hang;
         if (mult_start) begin
            acc_q    <= matmul(active_w, data_q);
            acc_full <= 1'b1;
         end else if (acc_out_pop) begin
            acc_full <= 1'b0;
         end
      end
   end

   always @(posedge clk) if (rst_n) begin
      cnt_nwp += int'(new_weight_push); cnt_ld += int'(weight_ld_start); cnt_sw += int'(weight_swap);
      cnt_dp  += int'(data_in_push);    cnt_ms += int'(mult_start);      cnt_pop += int'(acc_out_pop);
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [RB-1:0] act, input logic [RB-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One-hot strobes, each only while its rdy is high.
   always @(negedge clk) if (rst_n) begin
      logic [5:0] s;
      s = {new_weight_push, weight_ld_start, weight_swap, data_in_push, mult_start, acc_out_pop};
      if (s != '0) begin
         checks++;
         if ($countones(s) > 1 || (new_weight_push && !new_weight_rdy) || (acc_out_pop && !acc_out_rdy)
             || (weight_ld_start && !weight_ld_rdy) || (data_in_push && !data_in_rdy)
             || (mult_start && (!mult_rdy || mult_done))) begin
            failures++;
            $display("FAIL strobe_rule actual=%b at cycle %0d", s, cyc);
         end
      end
   end

   function automatic logic [WB-1:0] pk8(input int a, input int b, input int c, input int d);
      logic [31:0] ta, tb, tc, td;
      ta = a; tb = b; tc = c; td = d;
      return {td[7:0], tc[7:0], tb[7:0], ta[7:0]};
   endfunction

   function automatic logic [RB-1:0] pk32(input int a, input int b, input int c, input int d);
      logic [31:0] ta, tb, tc, td;
      ta = a; tb = b; tc = c; td = d;
      return {td, tc, tb, ta};
   endfunction

   task automatic send_cmd(input logic [WB-1:0] w, input logic [WB-1:0] d, input logic reuse);
      @(negedge clk);
      cmd_weight = w; cmd_data = d; cmd_reuse_w = reuse; cmd_valid = 1'b1;
      for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
      chk("cmd_accept", RB'(cmd_ready), RB'(1));
      acc_cyc = cyc;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_result();
      @(negedge clk);
      for (int i = 0; i < 200 && !result_valid; i++) @(negedge clk);
      chk("result_valid_wait", RB'(result_valid), RB'(1));
   endtask

   task automatic take_result();
      result_ready = 1'b1;
      @(posedge clk);
      #1 result_ready = 1'b0;
      @(negedge clk);
      chk("rv_cleared", RB'(result_valid), RB'(0));
      chk("ready_again", RB'(cmd_ready), RB'(1));
   endtask

   task automatic wait_mult_start(output int m);
      m = 0;
      for (int i = 0; i < 60 && !mult_start; i++) @(negedge clk);
      chk("mult_start_seen", RB'(mult_start), RB'(1));
      m = cyc;
   endtask

   task automatic chk_quiet(input string name);
      chk(name, RB'({cmd_ready, result_valid, err, new_weight_push, weight_ld_start, weight_swap,
                     data_in_push, mult_start, acc_out_pop}), RB'(0));
   endtask

   typedef struct {
      logic [WB-1:0] w;
      logic [WB-1:0] d;
      logic          reuse;
      logic [RB-1:0] res;
      int            lat;
      int            wp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int b_nwp, b_ld, b_sw, b_dp, b_ms, b_pop, m;
      vecs[0] = '{pk8(1,2,3,4),         pk8(5,6,7,8),         1'b1, pk32(19,22,43,50),             10, 1};
      vecs[1] = '{pk8(9,9,9,9),         pk8(1,0,0,1),         1'b1, pk32(1,2,3,4),                 6,  0};
      vecs[2] = '{pk8(2,0,0,3),         pk8(1,2,3,4),         1'b0, pk32(2,4,9,12),                10, 1};
      vecs[3] = '{pk8(0,0,0,0),         pk8(5,6,7,8),         1'b1, pk32(10,12,21,24),             6,  0};
      vecs[4] = '{pk8(1,2,3,4),         pk8(5,6,7,8),         1'b0, pk32(19,22,43,50),             10, 1};
      vecs[5] = '{pk8(100,100,100,100), pk8(100,100,100,100), 1'b0, pk32(20000,20000,20000,20000), 10, 1};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_reuse_w = 1'b0; cmd_weight = '0; cmd_data = '0;
      result_ready = 1'b0; nw_rdy = 1'b1; mult_hang = 1'b0;

      repeat (3) @(negedge clk);
      chk_quiet("reset_outputs");
      chk("reset_result", result, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", RB'(cmd_ready), RB'(1));

      for (int v = 0; v < 6; v++) begin
         b_nwp = cnt_nwp; b_ld = cnt_ld; b_sw = cnt_sw; b_dp = cnt_dp; b_ms = cnt_ms; b_pop = cnt_pop;
         send_cmd(vecs[v].w, vecs[v].d, vecs[v].reuse);
         wait_result();
         chk($sformatf("v%0d_latency", v), RB'(cyc - acc_cyc), RB'(vecs[v].lat));
         chk($sformatf("v%0d_result", v), result, vecs[v].res);
         chk($sformatf("v%0d_wpush", v), RB'(cnt_nwp - b_nwp), RB'(vecs[v].wp));
         chk($sformatf("v%0d_wld", v),   RB'(cnt_ld - b_ld),   RB'(vecs[v].wp));
         chk($sformatf("v%0d_wswap", v), RB'(cnt_sw - b_sw),   RB'(vecs[v].wp));
         chk($sformatf("v%0d_dmpop", v), RB'({cnt_dp - b_dp, cnt_ms - b_ms, cnt_pop - b_pop}), RB'({32'd1, 32'd1, 32'd1}));
         take_result();
      end

      // new_weight_rdy low for 3 cycles: push only in the first rdy-high cycle.
      b_nwp = cnt_nwp;
      nw_rdy = 1'b0;
      send_cmd(pk8(1,2,3,4), pk8(5,6,7,8), 1'b0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         else @(negedge clk);
         chk($sformatf("stall_push_low%0d", i), RB'(new_weight_push), RB'(0));
      end
      @(posedge clk);
      #1 nw_rdy = 1'b1;
      @(negedge clk);
      chk("stall_push_first_rdy", RB'(new_weight_push), RB'(1));
      @(negedge clk);
      chk("stall_push_dropped", RB'(new_weight_push), RB'(0));
      wait_result();
      chk("stall_latency", RB'(cyc - acc_cyc), RB'(13));
      chk("stall_result", result, pk32(19,22,43,50));
      chk("stall_push_count", RB'(cnt_nwp - b_nwp), RB'(1));
      take_result();

      // Result back-pressure for 5 cycles while a new command is offered.
      send_cmd(pk8(0,0,0,0), pk8(5,6,7,8), 1'b1);
      wait_result();
      b_dp = cnt_dp;
      cmd_data = pk8(1,0,0,1); cmd_reuse_w = 1'b1; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("hold%0d_rv", i), RB'(result_valid), RB'(1));
         chk($sformatf("hold%0d_result", i), result, pk32(19,22,43,50));
         chk($sformatf("hold%0d_cmd_ready", i), RB'(cmd_ready), RB'(0));
      end
      chk("hold_cmd_ignored", RB'(cnt_dp - b_dp), RB'(0));
      @(posedge clk);
      #1 result_ready = 1'b1;
      @(negedge clk);
      chk("hold_sixth_rv", RB'(result_valid), RB'(1));
      @(posedge clk);
      #1 result_ready = 1'b0;
      @(negedge clk);
      chk("hold_released_rv", RB'(result_valid), RB'(0));
      chk("hold_released_ready", RB'(cmd_ready), RB'(1));
      acc_cyc = cyc;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_result();
      chk("queued_latency", RB'(cyc - acc_cyc), RB'(6));
      chk("queued_result", result, pk32(1,2,3,4));
      take_result();

      // Watchdog: mult_done never arrives.
      mult_hang = 1'b1;
      send_cmd(pk8(0,0,0,0), pk8(5,6,7,8), 1'b1);
      @(negedge clk);
      wait_mult_start(m);
      for (int i = 0; i < 100 && !err; i++) @(negedge clk);
      chk("timeout_cycles", RB'(cyc - m), RB'(17));
      chk("timeout_err", RB'(err), RB'(1));
      cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("err_sticky", RB'({err, cmd_ready, result_valid}), RB'(3'b100));
      chk("err_no_strobes", RB'({new_weight_push, weight_ld_start, weight_swap, data_in_push, mult_start, acc_out_pop}), RB'(0));
      cmd_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_quiet("err_reset_outputs");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("err_reset_idle", RB'({cmd_ready, err}), RB'(2'b10));
      chk("err_reset_result", result, '0);

      // Reset in the middle of a multiply.
      send_cmd(pk8(7,7,7,7), pk8(3,3,3,3), 1'b0);
      @(negedge clk);
      wait_mult_start(m);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_quiet("midmult_reset_outputs");
      @(posedge clk);
      #1 rst_n = 1'b1;
      mult_hang = 1'b0;
      @(negedge clk);
      chk("midmult_idle", RB'(cmd_ready), RB'(1));
      chk("midmult_regs_clear", RB'({new_weight_in, data_in}), RB'(0));

      // Reuse request right after reset must still load weights.
      b_nwp = cnt_nwp; b_sw = cnt_sw;
      send_cmd(pk8(1,2,3,4), pk8(5,6,7,8), 1'b1);
      wait_result();
      chk("post_reset_latency", RB'(cyc - acc_cyc), RB'(10));
      chk("post_reset_result", result, pk32(19,22,43,50));
      chk("post_reset_wload", RB'({cnt_nwp - b_nwp, cnt_sw - b_sw}), RB'({32'd1, 32'd1}));
      take_result();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=%0d cycles required=completion", cyc);
      $fatal(1, "bench did not complete");
   end

endmodule
